// File: rtl/i2c_master_burst_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_master_burst_ctrl
//
// Byte-level I2C master sequencer. It accepts one burst request, optionally
// issues START, and then moves up to NBYTES bytes through a bit-level
// controller one bit command at a time. It finishes with an optional STOP.
//
// Build option:
//   I2C_BURST_NACK_ABORT_EN - when defined, a slave NACK on any written byte
//                             abandons the remaining bytes and always issues
//                             STOP. When undefined, every byte is written,
//                             and any NACK is still reported in nack_err.
//
// Ports:
//   clk        system clock, rising edge
//   Reset_n    asynchronous active-low reset
//   rst        synchronous active-high soft reset (beats i2c_al and cmd_valid)
//   cmd_valid / cmd_ready           burst request handshake (ready only in IDLE)
//   cmd_start, cmd_stop             issue START before / STOP after the bytes
//   cmd_read, cmd_write             direction (both set -> read, neither -> no data)
//   cmd_len    byte count minus 1
//   wdata      write bytes, byte k at [8k+7:8k], sent in order 0..cmd_len
//   rdata      read bytes, byte k at [8k+7:8k]; bytes above cmd_len are kept
//   done       one-cycle pulse when IDLE is re-entered after a burst
//   ack_out    last slave acknowledge bit seen on a write (1 = NACK)
//   nack_err   a written byte was NACKed during the last burst
//   al_err     one-cycle pulse, together with done, on arbitration loss
//   busy       high in every state except IDLE
//   core_cmd   bit-controller command: NOP 0000, START 0001, STOP 0010,
//              WRITE 0100, READ 1000; held until core_ack
//   core_txd   bit driven with WRITE commands
//   core_ack   bit-controller completion strobe
//   core_rxd   bit sampled by the bit controller
//   i2c_al     arbitration lost
// ---------------------------------------------------------------------------
module i2c_master_burst_ctrl #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned LEN_W  = 2
) (
    input  logic                  clk,
    input  logic                  Reset_n,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic                  cmd_read,
    input  logic                  cmd_write,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [8*NBYTES-1:0]   wdata,
    output logic [8*NBYTES-1:0]   rdata,
    output logic                  done,
    output logic                  ack_out,
    output logic                  nack_err,
    output logic                  al_err,
    output logic                  busy,
    output logic [3:0]            core_cmd,
    output logic                  core_txd,
    input  logic                  core_ack,
    input  logic                  core_rxd,
    input  logic                  i2c_al
);

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WRITE,
        S_READ,
        S_ACK,
        S_STOP
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    len_q;
    logic                stp_q;
    logic                rd_q;
    logic                wr_q;
    logic [8*NBYTES-1:0] wbuf;
    logic [7:0]          sh;
    logic [2:0]          bit_cnt;
    logic [LEN_W-1:0]    byte_cnt;
    logic                nack_seen;

    logic [LEN_W-1:0]    byte_nxt;
    logic                last;
    logic                f_rd;
    logic                f_wr;
    logic                f_stp;
    logic [7:0]          f_byte;
    logic [7:0]          wbyte_nxt;
    logic                enter_data;

    // In IDLE the request fields are still on the inputs. Use them directly
    // so that a burst without START can go straight to its first data bit.
    always_comb begin
        byte_nxt   = byte_cnt + 1'b1;
        last       = (byte_cnt == len_q);
        wbyte_nxt  = wbuf[{byte_nxt, 3'b000} +: 8];
        if (state == S_IDLE) begin
            f_rd   = cmd_read;
            f_wr   = cmd_write;
            f_stp  = cmd_stop;
            f_byte = wdata[7:0];
        end else begin
            f_rd   = rd_q;
            f_wr   = wr_q;
            f_stp  = stp_q;
            f_byte = wbuf[7:0];
        end
        enter_data = ((state == S_IDLE) && cmd_valid && !cmd_start) ||
                     ((state == S_START) && core_ack);
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            core_cmd  <= CMD_NOP;
            core_txd  <= 1'b1;
            rdata     <= '0;
            done      <= 1'b0;
            ack_out   <= 1'b0;
            nack_err  <= 1'b0;
            al_err    <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            len_q     <= '0;
            stp_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wbuf      <= '0;
            sh        <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            nack_seen <= 1'b0;
        end else if (rst) begin
            state     <= S_IDLE;
            core_cmd  <= CMD_NOP;
            core_txd  <= 1'b1;
            rdata     <= '0;
            done      <= 1'b0;
            ack_out   <= 1'b0;
            nack_err  <= 1'b0;
            al_err    <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            len_q     <= '0;
            stp_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wbuf      <= '0;
            sh        <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            nack_seen <= 1'b0;
        end else if ((state != S_IDLE) && i2c_al) begin
            state     <= S_IDLE;
            core_cmd  <= CMD_NOP;
            core_txd  <= 1'b1;
            done      <= 1'b1;
            al_err    <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            nack_err  <= nack_seen;
        end else begin
            done   <= 1'b0;
            al_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        len_q     <= cmd_len;
                        stp_q     <= cmd_stop;
                        rd_q      <= cmd_read;
                        wr_q      <= cmd_write & ~cmd_read;
                        wbuf      <= wdata;
                        byte_cnt  <= '0;
                        bit_cnt   <= '0;
                        nack_seen <= 1'b0;
                        nack_err  <= 1'b0;
                        if (cmd_start) begin
                            state     <= S_START;
                            core_cmd  <= CMD_START;
                            core_txd  <= 1'b1;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                        end
                    end
                end

                S_START: ;  // exit handled by enter_data below

                S_WRITE: begin
                    if (core_ack) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            // Release SDA and sample the slave acknowledge.
                            state    <= S_ACK;
                            core_cmd <= CMD_READ;
                            core_txd <= 1'b1;
                        end else begin
                            core_txd <= sh[6];
                            sh       <= {sh[6:0], 1'b0};
                        end
                    end
                end

                S_READ: begin
                    if (core_ack) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        sh      <= {sh[6:0], core_rxd};
                        if (bit_cnt == 3'd7) begin
                            rdata[{byte_cnt, 3'b000} +: 8] <= {sh[6:0], core_rxd};
                            state    <= S_ACK;
                            core_cmd <= CMD_WRITE;
                            // Master NACKs only the final byte of a stopping read.
                            core_txd <= last ? stp_q : 1'b0;
                        end
                    end
                end

                S_ACK: begin
                    if (core_ack) begin
                        if (wr_q) begin
                            ack_out <= core_rxd;
                            if (core_rxd) begin
                                nack_seen <= 1'b1;
                            end
                        end
`ifdef I2C_BURST_NACK_ABORT_EN
                        if (wr_q && core_rxd) begin
                            state    <= S_STOP;
                            core_cmd <= CMD_STOP;
                            core_txd <= 1'b1;
                        end else
`endif
                        if (last) begin
                            if (stp_q) begin
                                state    <= S_STOP;
                                core_cmd <= CMD_STOP;
                                core_txd <= 1'b1;
                            end else begin
                                state     <= S_IDLE;
                                core_cmd  <= CMD_NOP;
                                core_txd  <= 1'b1;
                                busy      <= 1'b0;
                                cmd_ready <= 1'b1;
                                done      <= 1'b1;
                                nack_err  <= nack_seen | (wr_q & core_rxd);
                            end
                        end else begin
                            byte_cnt <= byte_nxt;
                            bit_cnt  <= '0;
                            if (rd_q) begin
                                state    <= S_READ;
                                core_cmd <= CMD_READ;
                                core_txd <= 1'b1;
                            end else begin
                                state    <= S_WRITE;
                                core_cmd <= CMD_WRITE;
                                core_txd <= wbyte_nxt[7];
                                sh       <= wbyte_nxt;
                            end
                        end
                    end
                end

                S_STOP: begin
                    if (core_ack) begin
                        state     <= S_IDLE;
                        core_cmd  <= CMD_NOP;
                        core_txd  <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        done      <= 1'b1;
                        nack_err  <= nack_seen;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    core_cmd <= CMD_NOP;
                    core_txd <= 1'b1;
                end
            endcase

            // First phase after START, or straight from IDLE when no START is
            // requested. These assignments override the ones made above.
            if (enter_data) begin
                if (f_rd) begin
                    state     <= S_READ;
                    core_cmd  <= CMD_READ;
                    core_txd  <= 1'b1;
                    busy      <= 1'b1;
                    cmd_ready <= 1'b0;
                end else if (f_wr) begin
                    state     <= S_WRITE;
                    core_cmd  <= CMD_WRITE;
                    core_txd  <= f_byte[7];
                    sh        <= f_byte;
                    busy      <= 1'b1;
                    cmd_ready <= 1'b0;
                end else if (f_stp) begin
                    state     <= S_STOP;
                    core_cmd  <= CMD_STOP;
                    core_txd  <= 1'b1;
                    busy      <= 1'b1;
                    cmd_ready <= 1'b0;
                end else begin
                    state     <= S_IDLE;
                    core_cmd  <= CMD_NOP;
                    core_txd  <= 1'b1;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_burst_ctrl
//
// Bench for i2c_master_burst_ctrl. A bit-controller model acknowledges each
// command after two cycles. It pops the expected command, core_txd and the
// core_rxd to return from a scoreboard queue that is filled when each burst
// request is driven.
// Define I2C_BURST_NACK_ABORT_EN to check the NACK-abort build.
// ---------------------------------------------------------------------------
module tb_i2c_master_burst_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned LW = 2;

    localparam logic [3:0] C_NOP = 4'b0000;
    localparam logic [3:0] C_STA = 4'b0001;
    localparam logic [3:0] C_STO = 4'b0010;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b1000;

    logic            clk;
    logic            Reset_n;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_start;
    logic            cmd_stop;
    logic            cmd_read;
    logic            cmd_write;
    logic [LW-1:0]   cmd_len;
    logic [8*NB-1:0] wdata;
    logic [8*NB-1:0] rdata;
    logic            done;
    logic            ack_out;
    logic            nack_err;
    logic            al_err;
    logic            busy;
    logic [3:0]      core_cmd;
    logic            core_txd;
    logic            core_ack;
    logic            core_rxd;
    logic            i2c_al;

    typedef struct packed {
        logic [3:0] cmd;
        logic       txd;
        logic       rxd;
    } bus_op_t;

    bus_op_t sb[$];
    int      n_cmp = 0;
    int      n_bad = 0;

    i2c_master_burst_ctrl #(
        .NBYTES (NB),
        .LEN_W  (LW)
    ) dut (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_stop  (cmd_stop),
        .cmd_read  (cmd_read),
        .cmd_write (cmd_write),
        .cmd_len   (cmd_len),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .ack_out   (ack_out),
        .nack_err  (nack_err),
        .al_err    (al_err),
        .busy      (busy),
        .core_cmd  (core_cmd),
        .core_txd  (core_txd),
        .core_ack  (core_ack),
        .core_rxd  (core_rxd),
        .i2c_al    (i2c_al)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_op(input logic [3:0] cmd, input logic txd, input logic rxd);
        bus_op_t op;
        op.cmd = cmd;
        op.txd = txd;
        op.rxd = rxd;
        sb.push_back(op);
    endtask

    // 8 WRITE bits MSB first, then the READ that samples the slave ACK.
    task automatic push_wr_byte(input logic [7:0] b, input logic nack);
        for (int i = 7; i >= 0; i--) push_op(C_WR, b[i], 1'b1);
        push_op(C_RD, 1'b1, nack);
    endtask

    // 8 READ bits returning b MSB first, then the master ACK WRITE.
    task automatic push_rd_byte(input logic [7:0] b, input logic mack);
        for (int i = 7; i >= 0; i--) push_op(C_RD, 1'b1, b[i]);
        push_op(C_WR, mack, 1'b1);
    endtask

    // Bit-controller model: acknowledges a pending command after two cycles
    // while the scoreboard still holds an expected operation.
    initial begin
        int      cnt;
        bus_op_t e;
        cnt      = 0;
        core_ack = 1'b0;
        core_rxd = 1'b1;
        forever begin
            @(negedge clk);
            core_ack = 1'b0;
            if (core_cmd != C_NOP && sb.size() > 0 && Reset_n && !rst) begin
                cnt++;
                if (cnt >= 2) begin
                    cnt = 0;
                    e   = sb.pop_front();
                    check("bus_cmd", {28'd0, core_cmd}, {28'd0, e.cmd});
                    check("bus_txd", {31'd0, core_txd}, {31'd0, e.txd});
                    core_rxd = e.rxd;
                    core_ack = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic send_req(input logic st, input logic sp, input logic rd, input logic wr,
                            input logic [LW-1:0] len, input logic [8*NB-1:0] d);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_start = st;
        cmd_stop  = sp;
        cmd_read  = rd;
        cmd_write = wr;
        cmd_len   = len;
        wdata     = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("req_busy", {31'd0, busy}, 32'd1);
        check("req_ready_lo", {31'd0, cmd_ready}, 32'd0);
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, sb.size(), 32'd0);
        sb.delete();
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input logic exp_nack);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"},  {31'd0, done}, 32'd1);
        check({tag, "_left"},  sb.size(), 32'd0);
        check({tag, "_al"},    {31'd0, al_err}, 32'd0);
        check({tag, "_nack"},  {31'd0, nack_err}, {31'd0, exp_nack});
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        check({tag, "_cmd"},   {28'd0, core_cmd}, 32'd0);
        check({tag, "_txd"},   {31'd0, core_txd}, 32'd1);
        sb.delete();
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n   = 1'b0;
        rst       = 1'b0;
        i2c_al    = 1'b0;
        cmd_valid = 1'b0;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        cmd_read  = 1'b0;
        cmd_write = 1'b0;
        cmd_len   = '0;
        wdata     = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_cmd",   {28'd0, core_cmd}, 32'd0);
        check("rst_txd",   {31'd0, core_txd}, 32'd1);
        check("rst_rdata", rdata, 32'd0);
        check("rst_nack",  {31'd0, nack_err}, 32'd0);
        Reset_n = 1'b1;
        @(negedge clk);

        // Two-byte write, slave ACKs both.
        push_op(C_STA, 1'b1, 1'b1);
        push_wr_byte(8'h5A, 1'b0);
        push_wr_byte(8'hA5, 1'b0);
        push_op(C_STO, 1'b1, 1'b1);
        send_req(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 32'h0000A55A);
        wait_done("wr2", 1'b0);
        check("wr2_ackout", {31'd0, ack_out}, 32'd0);
        check("wr2_rdata", rdata, 32'd0);

        // Three-byte read; master ACK bits 0, 0, 1.
        push_op(C_STA, 1'b1, 1'b1);
        push_rd_byte(8'h12, 1'b0);
        push_rd_byte(8'h34, 1'b0);
        push_rd_byte(8'h56, 1'b1);
        push_op(C_STO, 1'b1, 1'b1);
        send_req(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0);
        wait_done("rd3", 1'b0);
        check("rd3_rdata", rdata, 32'h00563412);

        // Three-byte write, slave NACKs byte 0.
        push_op(C_STA, 1'b1, 1'b1);
        push_wr_byte(8'h11, 1'b1);
`ifndef I2C_BURST_NACK_ABORT_EN
        push_wr_byte(8'h22, 1'b0);
        push_wr_byte(8'h33, 1'b0);
`endif
        push_op(C_STO, 1'b1, 1'b1);
        send_req(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 32'h00332211);
        wait_done("nack", 1'b1);
`ifdef I2C_BURST_NACK_ABORT_EN
        check("nack_ackout", {31'd0, ack_out}, 32'd1);
`else
        check("nack_ackout", {31'd0, ack_out}, 32'd0);
`endif
        check("nack_rdata", rdata, 32'h00563412);

        // Single-byte read without STOP (read+write both set -> read).
        push_op(C_STA, 1'b1, 1'b1);
        push_rd_byte(8'hC3, 1'b0);
        send_req(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'hFFFFFFFF);
        wait_done("rd_nostop", 1'b0);
        check("rd_nostop_rdata", rdata, 32'h005634C3);

        // Following write uses a repeated START.
        push_op(C_STA, 1'b1, 1'b1);
        push_wr_byte(8'h7E, 1'b0);
        push_op(C_STO, 1'b1, 1'b1);
        send_req(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0000007E);
        wait_done("rstart", 1'b0);
        check("rstart_rdata", rdata, 32'h005634C3);

        // Arbitration loss while idle has no effect.
        i2c_al = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_al_done", {31'd0, done}, 32'd0);
        check("idle_al_err",  {31'd0, al_err}, 32'd0);
        check("idle_al_busy", {31'd0, busy}, 32'd0);
        i2c_al = 1'b0;
        @(negedge clk);

        // Arbitration loss during bit 4 of a read.
        push_op(C_STA, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) push_op(C_RD, 1'b1, 1'b1);
        send_req(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0);
        wait_empty("al");
        check("al_pre_cmd", {28'd0, core_cmd}, {28'd0, C_RD});
        i2c_al = 1'b1;
        @(negedge clk);
        i2c_al = 1'b0;
        check("al_done",  {31'd0, done}, 32'd1);
        check("al_err",   {31'd0, al_err}, 32'd1);
        check("al_cmd",   {28'd0, core_cmd}, 32'd0);
        check("al_txd",   {31'd0, core_txd}, 32'd1);
        check("al_ready", {31'd0, cmd_ready}, 32'd1);
        check("al_busy",  {31'd0, busy}, 32'd0);
        check("al_rdata", rdata, 32'h005634C3);
        @(negedge clk);
        check("al_done_pulse", {31'd0, done}, 32'd0);
        check("al_err_pulse",  {31'd0, al_err}, 32'd0);

        // Soft reset mid-read beats i2c_al and cmd_valid.
        push_op(C_STA, 1'b1, 1'b1);
        push_op(C_RD, 1'b1, 1'b0);
        push_op(C_RD, 1'b1, 1'b1);
        send_req(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0);
        wait_empty("srst");
        rst       = 1'b1;
        i2c_al    = 1'b1;
        cmd_start = 1'b1;
        cmd_write = 1'b1;
        cmd_read  = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("srst_busy",  {31'd0, busy}, 32'd0);
        check("srst_done",  {31'd0, done}, 32'd0);
        check("srst_al",    {31'd0, al_err}, 32'd0);
        check("srst_cmd",   {28'd0, core_cmd}, 32'd0);
        check("srst_txd",   {31'd0, core_txd}, 32'd1);
        check("srst_rdata", rdata, 32'd0);
        check("srst_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        check("srst_noaccept", {31'd0, busy}, 32'd0);
        rst       = 1'b0;
        i2c_al    = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("srst_after_busy", {31'd0, busy}, 32'd0);
        check("srst_after_done", {31'd0, done}, 32'd0);

        // Hard reset mid-write with cmd_valid held, then a new burst.
        push_op(C_STA, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) push_op(C_WR, 1'b0, 1'b1);
        send_req(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 32'h00332211);
        wait_empty("hrst");
        cmd_start = 1'b1;
        cmd_stop  = 1'b1;
        cmd_read  = 1'b0;
        cmd_write = 1'b1;
        cmd_len   = 2'd0;
        wdata     = 32'h0000003C;
        cmd_valid = 1'b1;
        Reset_n   = 1'b0;
        #1;
        check("hrst_cmd",   {28'd0, core_cmd}, 32'd0);
        check("hrst_txd",   {31'd0, core_txd}, 32'd1);
        check("hrst_busy",  {31'd0, busy}, 32'd0);
        check("hrst_done",  {31'd0, done}, 32'd0);
        check("hrst_ackout", {31'd0, ack_out}, 32'd0);
        check("hrst_nack",  {31'd0, nack_err}, 32'd0);
        check("hrst_al",    {31'd0, al_err}, 32'd0);
        check("hrst_rdata", rdata, 32'd0);
        @(negedge clk);
        check("hrst_nodone", {31'd0, done}, 32'd0);
        push_op(C_STA, 1'b1, 1'b1);
        push_wr_byte(8'h3C, 1'b0);
        push_op(C_STO, 1'b1, 1'b1);
        Reset_n = 1'b1;
        #1;
        check("hrst_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hrst_accept", {31'd0, busy}, 32'd1);
        wait_done("post_rst", 1'b0);
        check("post_rst_rdata", rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_master_burst_ctrl.md
I2C_MASTER_BURST_CTRL -- requirements
Module: i2c_master_burst_ctrl

Interface
REQ-001 SHALL provide parameter NBYTES, default 4, giving the maximum bytes per burst (legal range 1..16).
REQ-002 SHALL provide parameter LEN_W, default 2, giving the width of cmd_len; LEN_W = clog2(NBYTES), minimum 1.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high soft reset.
REQ-006 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): burst request handshake.
REQ-007 SHALL have ports cmd_start, cmd_stop, cmd_read, cmd_write (inputs, 1 each): burst options.
REQ-008 SHALL have port cmd_len, input, LEN_W bits: byte count minus 1.
REQ-009 SHALL have ports wdata (input) and rdata (output), each 8*NBYTES bits; byte k occupies [8k+7:8k].
REQ-010 SHALL have ports done, ack_out, nack_err, al_err and busy, outputs, 1 bit each.
REQ-011 SHALL have port core_cmd, output, 4 bits: bit-controller command (NOP 0000, START 0001, STOP 0010, WRITE 0100, READ 1000).
REQ-012 SHALL have ports core_txd (output, 1), core_ack (input, 1), core_rxd (input, 1) and i2c_al (input, 1): bit-controller link.

Function
REQ-013 SHALL implement the states IDLE, START, WRITE, READ, ACK and STOP.
REQ-014 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&cmd_ready all cmd_* fields and wdata SHALL be captured.
REQ-015 A request with neither cmd_read nor cmd_write SHALL perform only the optional START and optional STOP.
REQ-016 A request with both cmd_read and cmd_write SHALL be treated as read.
REQ-017 core_cmd SHALL be registered and change on the cycle after acceptance or after core_ack, and SHALL be held until core_ack.
REQ-018 Transition order: IDLE -> START (if cmd_start) -> WRITE|READ -> ACK -> next byte or STOP (if cmd_stop) or IDLE.
REQ-019 Bytes SHALL be sent in index order 0..cmd_len, MSB first; core_txd SHALL present the current bit while WRITE is issued.
REQ-020 In WRITE, the ACK phase SHALL issue READ; the sampled core_rxd (1 = NACK) SHALL be stored in ack_out.
REQ-021 In READ, 8 core_rxd bits SHALL be shifted MSB first into rdata byte k; the ACK phase SHALL issue WRITE.
REQ-022 Master ACK on reads: core_txd = 0 for bytes 0..cmd_len-1; the last byte uses core_txd = cmd_stop (NACK only when stopping).
REQ-023 Bit counter SHALL be 3 bits, byte counter LEN_W bits; the burst SHALL end when the byte counter equals the captured cmd_len, with no wrap.
REQ-024 done SHALL pulse for exactly 1 cycle on the cycle IDLE is re-entered after any burst, including aborts.
REQ-025 busy SHALL be 1 in every state other than IDLE.
REQ-026 i2c_al=1 in any non-IDLE state SHALL force IDLE, core_cmd=NOP and core_txd=1, and SHALL pulse al_err together with done; rdata SHALL be unchanged.
REQ-027 i2c_al=1 in IDLE SHALL be ignored.
REQ-028 rdata bytes above cmd_len SHALL retain their previous values.
REQ-029 rdata SHALL be updated during the burst; it is valid only when done=1 with al_err=0.

Reset
REQ-030 Reset_n=0 SHALL immediately set state IDLE, core_cmd=NOP, core_txd=1, rdata=0, and done, ack_out, nack_err, al_err, busy=0.
REQ-031 rst=1 SHALL apply the same values synchronously and SHALL take priority over i2c_al and cmd_valid.
REQ-032 A reset mid-burst SHALL drop the burst without a done pulse.

Configuration
REQ-033 With macro I2C_BURST_NACK_ABORT_EN defined, a slave NACK on any write byte SHALL end the remaining bytes, go to STOP (always, ignoring cmd_stop), then set nack_err=1 with done.
REQ-034 Without I2C_BURST_NACK_ABORT_EN, all bytes SHALL be written regardless of NACK; nack_err SHALL be set if any byte was NACKed.
REQ-035 In both cases nack_err SHALL be cleared on the next accepted request.

Verification
REQ-036 Write of 2 bytes (start=1, stop=1, len=1, wdata=16'hA55A), slave ACKs -> START, 8 WRITE bits 01011010, READ, 8 WRITE bits 10100101, READ, STOP; done=1, nack_err=0.
REQ-037 Read of 3 bytes (start=1, stop=1, len=2), slave returns 8'h12, 8'h34, 8'h56 -> rdata[23:0]=24'h563412; master ACK bits 0, 0, 1; then STOP.
REQ-038 Write of 3 bytes with NACK on byte 0 -> with the macro: STOP after byte 0, nack_err=1; without the macro: 3 bytes written, nack_err=1.
REQ-039 i2c_al=1 during bit 4 of a read -> next cycle state IDLE, core_cmd=0000, done=al_err=1 for 1 cycle, cmd_ready=1.
REQ-040 Reset_n low mid-write with cmd_valid held high -> all outputs at reset values immediately; after release a new burst is accepted with cmd_ready=1.
REQ-041 Read with stop=0, len=0 (NBYTES=1 build) -> no STOP issued, last ACK bit 0, done=1; then a write with start=1 gives a repeated START.
